// File: rtl/mux_pkg.sv
// Shared definitions for the streaming multiplexer.
//   mux_mode_e : select mode encoding (FIXED / ROUND_ROBIN)
//   clog2w()   : channel-id width for a given channel count (never below 1)
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search over NUM_CH requests.
//   req         : request vector, one bit per channel
//   ptr         : channel with highest priority this cycle (must be < NUM_CH)
//   grant_valid : at least one request present
//   grant_idx   : first requesting channel at or after ptr, wrapping
// The request vector is doubled: the low copy is masked to channels >= ptr,
// the high copy is unmasked, so the lowest set bit of the doubled vector is
// the wrapped round-robin winner.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = clog2w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [2*NUM_CH-1:0] dbl;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_dbl
        assign dbl[i]          = req[i] && (i >= int'(ptr));
        assign dbl[NUM_CH + i] = req[i];
    end

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (dbl[i]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(i % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 streaming multiplexer with a single registered output stage.
//   clk, rst_n : rising-edge clock, async active-low reset
//   mode       : 0 = FIXED (sel_fixed picks the channel), 1 = ROUND_ROBIN
//   sel_fixed  : channel select in FIXED mode; out-of-range selects nothing
//   in_valid / in_data / in_ready : per-channel stream inputs, in_ready one-hot or zero
//   out_valid / out_data / out_ch / out_ready : registered output stream
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_fixed,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    mux_mode_e         mode_e;
    logic [SEL_W-1:0]  rr_ptr;
    logic              rr_vld;
    logic [SEL_W-1:0]  rr_idx;
    logic              fix_hit;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              load_en;
    logic              xfer;

    assign mode_e = mux_mode_e'(mode);

    rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant_valid (rr_vld),
        .grant_idx   (rr_idx)
    );

    // Compare against each legal index so an out-of-range select simply
    // matches nothing instead of indexing past the vector.
    always_comb begin
        fix_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_fixed == SEL_W'(i)) fix_hit = in_valid[i];
        end
    end

    assign gnt_vld = (mode_e == MODE_RR) ? rr_vld : fix_hit;
    assign gnt_idx = (mode_e == MODE_RR) ? rr_idx : sel_fixed;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    // Single stage that refills in the cycle it drains: no bubbles.
    assign load_en = !out_valid || out_ready;
    assign xfer    = rst_n && load_en && gnt_vld;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_rdy
        assign in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_ch    <= gnt_idx;
                // Pointer only moves on RR grants; FIXED mode leaves it frozen.
                if (mode_e == MODE_RR)
                    rr_ptr <= (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + SEL_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [SW-1:0] sel_fixed;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_ch;
    logic          out_ready;

    // 10-channel instance for the non-power-of-two cases
    logic          t_mode;
    logic [3:0]    t_sel;
    logic [9:0]    t_iv;
    logic [79:0]   t_id;
    logic [9:0]    t_ir;
    logic          t_ov;
    logic [DW-1:0] t_od;
    logic [3:0]    t_och;
    logic          t_ordy;

    int n_chk = 0;
    int n_err = 0;

    rr_stream_mux #(.NUM_CH(N), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_fixed(sel_fixed),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.NUM_CH(10), .DATA_W(DW)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .mode(t_mode), .sel_fixed(t_sel),
        .in_valid(t_iv), .in_data(t_id), .in_ready(t_ir),
        .out_valid(t_ov), .out_data(t_od), .out_ch(t_och),
        .out_ready(t_ordy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference grant: -1 means no grant.
    function automatic int mdl_grant(input logic md, input logic [SW-1:0] sel,
                                     input logic [N-1:0] v, input int p);
        if (!md) return (int'(sel) < N && v[sel]) ? int'(sel) : -1;
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Behavioural model of the output register and RR pointer
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_ch;
    int            m_ptr;
    logic [SW+DW-1:0] sb_q[$];

    always @(posedge clk or negedge rst_n) begin : mdl
        int   g;
        logic le;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
            m_ptr   <= 0;
            sb_q.delete();
        end else begin
            le = !m_valid || out_ready;
            g  = mdl_grant(mode, sel_fixed, in_valid, m_ptr);
            if (le) begin
                if (g >= 0) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data[g*DW +: DW];
                    m_ch    <= SW'(g);
                    if (mode) m_ptr <= (g + 1) % N;
                    sb_q.push_back({SW'(g), in_data[g*DW +: DW]});
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison and beat scoreboard, sampled mid-cycle
    always @(negedge clk) begin : chkr
        int           g;
        logic [N-1:0] er;
        logic [SW+DW-1:0] e;
        g  = mdl_grant(mode, sel_fixed, in_valid, m_ptr);
        er = '0;
        if (rst_n && (!m_valid || out_ready) && g >= 0) er[g] = 1'b1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
        chk("in_ready",  32'(in_ready),  32'(er));
        if (rst_n && out_valid && out_ready) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
            chk("sb_beat", 32'({out_ch, out_data}), 32'(e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) in_data[c*DW +: DW] = DW'($urandom);
    endtask

    initial begin : stim
        logic [DW-1:0] d;
        int r;
        rst_n = 1'b1; mode = 1'b0; sel_fixed = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        t_mode = 1'b0; t_sel = '0; t_iv = '0; t_id = '0; t_ordy = 1'b0;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_ovld", 32'(out_valid), 32'(0));
        rst_n = 1'b1;
        tick();

        // FIXED select of channel 5
        rand_data();
        mode = 1'b0; sel_fixed = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
        in_data[5*DW +: DW] = 8'hA5;
        #1 chk("fix_rdy", 32'(in_ready), 32'h0020);
        tick();
        chk("fix_data", 32'(out_data), 32'hA5);
        chk("fix_ch",   32'(out_ch),   32'd5);

        // RR fairness with wrap; pointer was frozen at 0 through FIXED
        mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rand_data();
            tick();
            chk("rr_seq", 32'(out_ch), 32'(k % N));
        end

        // Reset mid-traffic, then sparse RR restarting from channel 0
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ovld", 32'(out_valid), 32'(0));
        chk("mid_rst_och",  32'(out_ch),    32'(0));
        chk("mid_rst_rdy",  32'(in_ready),  32'(0));
        tick();
        rst_n = 1'b1;
        in_valid = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            rand_data();
            tick();
            chk("sparse", 32'(out_ch), (k % 2) ? 32'd15 : 32'd0);
        end

        // Backpressure: register must hold, no grants
        in_valid = 16'hFFFF;
        tick(); tick();
        out_ready = 1'b0;
        d = out_data;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            #1 chk("bp_rdy", 32'(in_ready), 32'(0));
            tick();
            chk("bp_data", 32'(out_data), 32'(d));
            chk("bp_vld",  32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;

        // Mode switch mid-burst; RR resumes from stored pointer
        for (int k = 0; k < 4; k++) begin rand_data(); tick(); end
        r = int'(out_ch);
        mode = 1'b0; sel_fixed = 4'd3;
        tick();
        chk("sw_fix", 32'(out_ch), 32'd3);
        tick(); tick();
        mode = 1'b1;
        tick();
        chk("sw_resume", 32'(out_ch), 32'((r + 1) % N));

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel_fixed = SW'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        // 10-channel instance: out-of-range select, top channel, RR wrap 9->0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        in_valid = '0;
        for (int c = 0; c < 10; c++) t_id[c*DW +: DW] = DW'(8'h30 + c);
        t_mode = 1'b0; t_sel = 4'd10; t_iv = 10'h3FF; t_ordy = 1'b1;
        #1 chk("n10_oor_rdy", 32'(t_ir), 32'(0));
        tick();
        chk("n10_oor_vld", 32'(t_ov), 32'(0));
        t_sel = 4'd9;
        #1 chk("n10_s9_rdy", 32'(t_ir), 32'h200);
        tick();
        chk("n10_s9_ch",   32'(t_och), 32'd9);
        chk("n10_s9_data", 32'(t_od),  32'h39);
        t_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("n10_rr", 32'(t_och), 32'(k % 10));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
